xillyvga_capture: RTL and testbench
===================================

Name: xillyvga_capture

Overview:
- Video-capture counterpart of the VGA scan-out path. It receives a DE/HSYNC/VSYNC/RGB pixel stream and packs each pixel into a 32-bit word.
- Words are buffered in an internal FIFO and written into a memory frame buffer through an AXI3 master write channel, using 16-beat INCR bursts.
- It sits beside the VGA block on the same memory interconnect, so a captured frame can be scanned out unchanged.

Parameters:
- FIFO_DEPTH, 64, pixel FIFO depth in 32-bit words (power of two, >=32).
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32).
- C_MAX_BURST_LEN, 16, full burst length in beats.

Ports:
- m_axi_aclk  in  1  sole clock; the pixel stream and AXI are both synchronous to it.
- m_axi_aresetn  in  1  asynchronous active-low reset.
- cfg_base_addr  in  32  frame buffer base address, 64-byte aligned.
- cfg_enable  in  1  capture enable, sampled at frame start.
- vid_valid  in  1  pixel-clock qualifier; the other vid_* inputs are meaningful only when it is 1.
- vid_de  in  1  active-video flag.
- vid_vsync  in  1  vertical sync, active high.
- vid_hsync  in  1  horizontal sync (unused beyond lint).
- vid_red, vid_green, vid_blue  in  8 each  pixel colour components.
- m_axi_awvalid / awready  out / in  1  write address handshake.
- m_axi_awaddr  out  32  burst start address.
- m_axi_awlen  out  4  beats minus one.
- m_axi_awsize  out  3  constant 3'b010.
- m_axi_awburst  out  2  constant 2'b01.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_awcache  out  4  constant 4'b0011.
- m_axi_wvalid / wready  out / in  1  write data handshake.
- m_axi_wdata  out  32  packed pixel {8'h00,R,G,B}.
- m_axi_wstrb  out  4  constant 4'hF.
- m_axi_wlast  out  1  final beat of the burst.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_bresp  in  2  write response code.
- frame_done  out  1  one-cycle pulse when a frame is fully written.
- overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.
- resp_err  out  1  sticky flag: a bresp other than OKAY was received.

Behaviour:
- Reset values: all valid outputs 0; awaddr = 0; awlen = 0; wlast = 0; frame_done = 0; overflow = 0; resp_err = 0. The FIFO is emptied, the FSM enters IDLE and capture is inactive.
- Pixel push, accepted only when all of the following hold:
  - vid_valid = 1, vid_de = 1, vid_vsync = 0, and capture is active.
  - The pushed word is {8'h00,R,G,B}.
  - If the FIFO is full, the pixel is dropped and overflow is set.
  - Pixels with vid_vsync = 1 are always ignored.
- Frame-start event: the rising edge of vid_vsync in a cycle with vid_valid = 1. It sets flush_req.
- Write FSM, one outstanding burst only:
  - IDLE:
    - count >= 16: latch awlen = 15 and enter ADDR. awvalid rises the cycle after count reaches 16.
    - Otherwise, flush_req and count > 0: latch awlen = count-1 and enter ADDR (short burst).
    - Otherwise, flush_req and count == 0: clear flush_req, set addr_ptr = cfg_base_addr, pulse frame_done, set capture active = cfg_enable, stay in IDLE.
  - ADDR: hold awvalid, awaddr = addr_ptr and awlen stable until awready. On the handshake, enter DATA.
  - DATA:
    - wvalid = 1 with wdata = FIFO head; pop on wready.
    - wlast = 1 on beat awlen.
    - After the last beat handshakes, enter RESP and advance addr_ptr by (awlen+1)*4.
    - W is never driven before its AW handshake.
  - RESP: bready = 1. When bvalid arrives, set resp_err if bresp != 2'b00, then return to IDLE.
- The FIFO can push and pop in the same cycle; count is unchanged in that case.
- count is sampled for short bursts only in IDLE. Pushes cannot occur during vsync, so a flush is exact.
- Full bursts never cross a 4 KB boundary, given the 64-byte-aligned base.
- If cfg_enable drops mid-frame, capture continues until the next frame-start event. The flush then completes and capture deactivates.
- overflow and resp_err clear only on reset.
- Reset asserted mid-burst aborts the burst immediately. The AXI outputs drop and all buffered data is lost.

Test Plan:
- Enable with base 0x1000_0000, frame-start, then 32 pixels with awready/wready/bvalid held high:
  - Two bursts, awlen 15, at 0x1000_0000 and 0x1000_0040.
  - wlast asserted on beats 16 and 32.
- 20 pixels, then a vsync rising edge:
  - A 16-beat burst, then a 4-beat burst (awlen = 3) at base+0x40.
  - frame_done pulses once; the next frame restarts at base.
- Hold awready low for 10 cycles:
  - awvalid, awaddr and awlen stay stable.
  - No wvalid appears before the AW handshake.
- Hold wready low while 70 pixels arrive with FIFO_DEPTH = 64:
  - overflow = 1; exactly 64 words are written, in order.
- Return bresp = 2'b10 on a burst:
  - resp_err = 1 and stays set; the following bursts proceed normally.
- Assert reset mid-DATA:
  - All outputs reach their reset values asynchronously.
  - After release, with no frame-start event, pixels are ignored and no AW is issued.

Source files
------------

// File: rtl/xillyvga_capture_if.sv
// ---------------------------------------------------------------------------
// xillyvga_capture_if
// AXI3 write-only channel bundle used by the capture block to reach the frame
// buffer interconnect.
//   master modport : drives AW/W, bready; observes awready/wready/bvalid/bresp
//   slave modport  : the interconnect / memory side
// ---------------------------------------------------------------------------
interface xillyvga_capture_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Write address channel
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [2:0]              awprot;
  logic [3:0]              awcache;
  // Write data channel
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  // Write response channel
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, awprot, awcache,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, awprot, awcache,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/xillyvga_capture.sv
// ---------------------------------------------------------------------------
// xillyvga_capture
// Captures a DE/VSYNC/RGB pixel stream, packs each pixel as {8'h00,R,G,B},
// buffers the words in a FIFO and writes them to a frame buffer with AXI3
// INCR bursts (16 beats, or a shorter final burst when a frame is flushed).
//
// Ports
//   m_axi_aclk, m_axi_aresetn : clock, asynchronous active-low reset
//   cfg_base_addr             : frame buffer base (64-byte aligned)
//   cfg_enable                : capture enable, sampled at frame start
//   vid_*                     : pixel stream, qualified by vid_valid
//   m_axi                     : AXI3 write channel (master modport)
//   frame_done                : one-cycle pulse when a frame is fully written
//   overflow                  : sticky, a pixel was dropped on a full FIFO
//   resp_err                  : sticky, a non-OKAY bresp was received
// ---------------------------------------------------------------------------
module xillyvga_capture #(
  parameter int FIFO_DEPTH         = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_BURST_LEN    = 16
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_aresetn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                          cfg_enable,
  input  logic                          vid_valid,
  input  logic                          vid_de,
  input  logic                          vid_vsync,
  input  logic                          vid_hsync,
  input  logic [7:0]                    vid_red,
  input  logic [7:0]                    vid_green,
  input  logic [7:0]                    vid_blue,
  xillyvga_capture_if.master            m_axi,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          resp_err
);

  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int WORD_BYTES = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  // ------------------------------------------------------------------------
  // Pixel FIFO
  // ------------------------------------------------------------------------
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [31:0]      rd_data_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;

  logic [31:0]      pix_word;
  logic             push_req;
  logic             fifo_full;
  logic             push;
  logic             pop;

  state_t                        state_q;
  logic                          awvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [3:0]                    awlen_q;
  logic                          wvalid_q;
  logic                          wlast_q;
  logic                          bready_q;
  logic [3:0]                    beat_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_ptr_q;
  logic                          frame_done_q;
  logic                          overflow_q;
  logic                          resp_err_q;
  logic                          active_q;
  logic                          flush_req_q;
  logic                          vsync_q;
  logic                          frame_start;
  logic                          burst_ready;

  assign pix_word  = {8'h00, vid_red, vid_green, vid_blue};
  // Pixels arriving during vsync are never stored, which keeps a flush exact.
  assign push_req  = vid_valid & vid_de & ~vid_vsync & active_q;
  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = push_req & ~fifo_full;
  assign pop       = (state_q == S_DATA) & wvalid_q & m_axi.wready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage and registered read. The head is re-read every cycle from the
  // next read pointer, so wdata always shows the current head one cycle
  // after a pop. A burst only drains words that were counted in IDLE, so a
  // read never collides with a same-cycle write to the entry it needs.
  always_ff @(posedge m_axi_aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pix_word;
    end
    rd_data_q <= mem_q[rd_ptr_d];
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Frame-start detection: rising vsync among valid pixel-clock samples
  // ------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      vsync_q <= 1'b0;
    end else if (vid_valid) begin
      vsync_q <= vid_vsync;
    end
  end

  assign frame_start = vid_valid & vid_vsync & ~vsync_q;
  assign burst_ready = (count_q >= CNT_W'(C_MAX_BURST_LEN));

  // ------------------------------------------------------------------------
  // Write FSM: one outstanding burst, all AXI outputs registered
  // ------------------------------------------------------------------------
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q      <= S_IDLE;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      awlen_q      <= '0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      beat_q       <= '0;
      addr_ptr_q   <= '0;
      frame_done_q <= 1'b0;
      resp_err_q   <= 1'b0;
      active_q     <= 1'b0;
      flush_req_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (burst_ready) begin
            awlen_q   <= 4'(C_MAX_BURST_LEN - 1);
            awaddr_q  <= addr_ptr_q;
            awvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end else if (flush_req_q && (count_q != '0)) begin
            // Tail of the frame: a short burst with whatever is buffered.
            awlen_q   <= 4'(count_q - CNT_W'(1));
            awaddr_q  <= addr_ptr_q;
            awvalid_q <= 1'b1;
            state_q   <= S_ADDR;
          end else if (flush_req_q) begin
            // Frame fully written: rewind to base and re-sample the enable.
            flush_req_q  <= 1'b0;
            addr_ptr_q   <= cfg_base_addr;
            frame_done_q <= 1'b1;
            active_q     <= cfg_enable;
          end
        end

        S_ADDR: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (awlen_q == 4'd0);
            beat_q    <= '0;
            state_q   <= S_DATA;
          end
        end

        S_DATA: begin
          if (pop) begin
            if (wlast_q) begin
              wvalid_q   <= 1'b0;
              wlast_q    <= 1'b0;
              bready_q   <= 1'b1;
              addr_ptr_q <= addr_ptr_q +
                            C_M_AXI_ADDR_WIDTH'((32'(awlen_q) + 32'd1) * 32'(WORD_BYTES));
              state_q    <= S_RESP;
            end else begin
              beat_q  <= beat_q + 4'd1;
              wlast_q <= ((beat_q + 4'd1) == awlen_q);
            end
          end
        end

        S_RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.bresp != 2'b00) begin
              resp_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // Placed last so a new frame start wins over a same-cycle flush clear.
      if (frame_start) begin
        flush_req_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = rd_data_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.bready  = bready_q;

  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign resp_err   = resp_err_q;

  // hsync carries no information the capture path needs.
  logic unused_ok;
  assign unused_ok = vid_hsync;

endmodule

// File: tb/tb_xillyvga_capture.sv
// ---------------------------------------------------------------------------
// tb_xillyvga_capture
// Directed bench for xillyvga_capture: full bursts, frame flush, AW stall,
// FIFO overflow, error response and mid-burst reset.
// ---------------------------------------------------------------------------
module tb_xillyvga_capture;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_base;
  logic        cfg_en;
  logic        vid_valid, vid_de, vid_vsync, vid_hsync;
  logic [7:0]  vid_r, vid_g, vid_b;
  logic        frame_done, overflow, resp_err;
  logic        awready_en, wready_en;
  logic [1:0]  bresp_val;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  xillyvga_capture_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  assign axi.awready = awready_en;
  assign axi.wready  = wready_en;
  assign axi.bvalid  = 1'b1;
  assign axi.bresp   = bresp_val;

  xillyvga_capture #(
    .FIFO_DEPTH(64), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_MAX_BURST_LEN(16)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .cfg_base_addr(cfg_base),
    .cfg_enable   (cfg_en),
    .vid_valid    (vid_valid),
    .vid_de       (vid_de),
    .vid_vsync    (vid_vsync),
    .vid_hsync    (vid_hsync),
    .vid_red      (vid_r),
    .vid_green    (vid_g),
    .vid_blue     (vid_b),
    .m_axi        (axi),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .resp_err     (resp_err)
  );

  // ------------------------------------------------------------------------
  // Bus monitor (records handshakes; all checking happens in the tests)
  // ------------------------------------------------------------------------
  logic [31:0] aw_addr_log[$];
  logic [3:0]  aw_len_log[$];
  logic [32:0] w_log[$];      // {wlast, wdata}
  int          b_cnt   = 0;
  int          fd_cnt  = 0;
  int          aw_pend = 0;
  int          early_w = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_pend <= 0;
    end else begin
      if (axi.wvalid && aw_pend == 0) early_w <= early_w + 1;
      if (axi.awvalid && axi.awready) begin
        aw_addr_log.push_back(axi.awaddr);
        aw_len_log.push_back(axi.awlen);
        aw_pend <= aw_pend + 1;
        $display("[%0t] AW addr=%h len=%0d", $time, axi.awaddr, axi.awlen);
      end
      if (axi.wvalid && axi.wready) begin
        w_log.push_back({axi.wlast, axi.wdata});
        if (axi.wlast) aw_pend <= aw_pend - 1;
      end
      if (axi.bvalid && axi.bready) begin
        b_cnt <= b_cnt + 1;
        $display("[%0t] B resp=%b", $time, axi.bresp);
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
    end
  end

  // ------------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------------
  function automatic logic [31:0] pix(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {8'h00, kb, kb ^ 8'h5A, ~kb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_pixels(input int first, input int n);
    logic [31:0] p;
    for (int i = 0; i < n; i++) begin
      tick();
      p = pix(first + i);
      vid_valid = 1'b1; vid_de = 1'b1; vid_vsync = 1'b0;
      vid_r = p[23:16]; vid_g = p[15:8]; vid_b = p[7:0];
    end
    tick();
    vid_valid = 1'b0; vid_de = 1'b0;
  endtask

  task automatic frame_start_evt();
    tick(); vid_valid = 1'b1; vid_de = 1'b0; vid_vsync = 1'b1;
    tick(); tick(); vid_vsync = 1'b0;
    tick(); vid_valid = 1'b0;
  endtask

  task automatic wait_w(input int target, input int budget);
    int c = 0;
    while (w_log.size() < target && c < budget) begin
      tick();
      c++;
    end
  endtask

  // ------------------------------------------------------------------------
  // Tests
  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    n_checks++; if (axi.awvalid !== 1'b0) $display("FAIL reset_awvalid: got %b want 0", axi.awvalid); else n_pass++;
    n_checks++; if (axi.wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b want 0", axi.wvalid); else n_pass++;
    n_checks++; if (axi.bready !== 1'b0) $display("FAIL reset_bready: got %b want 0", axi.bready); else n_pass++;
    n_checks++; if (axi.awaddr !== 32'h0) $display("FAIL reset_awaddr: got %h want 0", axi.awaddr); else n_pass++;
    n_checks++; if (axi.awlen !== 4'h0) $display("FAIL reset_awlen: got %h want 0", axi.awlen); else n_pass++;
    n_checks++; if (axi.wlast !== 1'b0) $display("FAIL reset_wlast: got %b want 0", axi.wlast); else n_pass++;
    n_checks++; if ({frame_done, overflow, resp_err} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {frame_done, overflow, resp_err}); else n_pass++;
    n_checks++; if ({axi.awsize, axi.awburst, axi.awcache, axi.wstrb} !== {3'b010, 2'b01, 4'b0011, 4'hF})
      $display("FAIL const_fields: got %h", {axi.awsize, axi.awburst, axi.awcache, axi.wstrb}); else n_pass++;
    tick();
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_bursts();
    int a0, w0;
    frame_start_evt(); idle(5);
    a0 = aw_addr_log.size(); w0 = w_log.size();
    send_pixels(0, 32);
    wait_w(w0 + 32, 300); idle(5);
    n_checks++; if (aw_addr_log.size() !== a0 + 2) $display("FAIL full_aw_count: got %0d want %0d", aw_addr_log.size() - a0, 2); else n_pass++;
    if (aw_addr_log.size() >= a0 + 2) begin
      n_checks++; if ({aw_addr_log[a0], aw_len_log[a0]} !== {BASE, 4'd15})
        $display("FAIL full_aw0: got %h/%0d want %h/15", aw_addr_log[a0], aw_len_log[a0], BASE); else n_pass++;
      n_checks++; if ({aw_addr_log[a0+1], aw_len_log[a0+1]} !== {BASE + 32'h40, 4'd15})
        $display("FAIL full_aw1: got %h/%0d want %h/15", aw_addr_log[a0+1], aw_len_log[a0+1], BASE + 32'h40); else n_pass++;
    end
    n_checks++; if (w_log.size() !== w0 + 32) $display("FAIL full_w_count: got %0d want 32", w_log.size() - w0); else n_pass++;
    if (w_log.size() >= w0 + 32) begin
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (w_log[w0+i] !== {(i == 15 || i == 31), pix(i)})
          $display("FAIL full_beat%0d: got %h want %h", i, w_log[w0+i], {(i == 15 || i == 31), pix(i)});
        else n_pass++;
      end
    end
  endtask

  task automatic test_short_flush();
    int a0, w0, f0;
    frame_start_evt(); idle(5);
    a0 = aw_addr_log.size(); w0 = w_log.size(); f0 = fd_cnt;
    send_pixels(40, 20);
    frame_start_evt();
    wait_w(w0 + 20, 300); idle(10);
    n_checks++; if (aw_addr_log.size() !== a0 + 2) $display("FAIL flush_aw_count: got %0d want 2", aw_addr_log.size() - a0); else n_pass++;
    if (aw_addr_log.size() >= a0 + 2) begin
      n_checks++; if ({aw_addr_log[a0], aw_len_log[a0]} !== {BASE, 4'd15})
        $display("FAIL flush_aw0: got %h/%0d want %h/15", aw_addr_log[a0], aw_len_log[a0], BASE); else n_pass++;
      n_checks++; if ({aw_addr_log[a0+1], aw_len_log[a0+1]} !== {BASE + 32'h40, 4'd3})
        $display("FAIL flush_aw1: got %h/%0d want %h/3", aw_addr_log[a0+1], aw_len_log[a0+1], BASE + 32'h40); else n_pass++;
    end
    n_checks++; if (w_log.size() !== w0 + 20) $display("FAIL flush_w_count: got %0d want 20", w_log.size() - w0); else n_pass++;
    if (w_log.size() >= w0 + 20) begin
      for (int i = 0; i < 20; i++) begin
        n_checks++;
        if (w_log[w0+i] !== {(i == 15 || i == 19), pix(40 + i)})
          $display("FAIL flush_beat%0d: got %h want %h", i, w_log[w0+i], {(i == 15 || i == 19), pix(40 + i)});
        else n_pass++;
      end
    end
    n_checks++; if (fd_cnt - f0 !== 1) $display("FAIL flush_frame_done: got %0d pulses want 1", fd_cnt - f0); else n_pass++;
    // Next frame starts over at the base address.
    a0 = aw_addr_log.size(); w0 = w_log.size();
    send_pixels(60, 16);
    wait_w(w0 + 16, 200); idle(5);
    n_checks++; if (aw_addr_log.size() !== a0 + 1) $display("FAIL restart_aw_count: got %0d want 1", aw_addr_log.size() - a0); else n_pass++;
    if (aw_addr_log.size() >= a0 + 1) begin
      n_checks++; if (aw_addr_log[a0] !== BASE) $display("FAIL restart_addr: got %h want %h", aw_addr_log[a0], BASE); else n_pass++;
    end
  endtask

  task automatic test_aw_stall();
    int a0, w0, c;
    frame_start_evt(); idle(5);
    awready_en = 1'b0;
    a0 = aw_addr_log.size(); w0 = w_log.size();
    send_pixels(70, 16);
    c = 0;
    while (!axi.awvalid && c < 30) begin tick(); c++; end
    n_checks++; if (axi.awvalid !== 1'b1) $display("FAIL stall_awvalid_rise: got %b want 1", axi.awvalid); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({axi.awvalid, axi.awaddr, axi.awlen, axi.wvalid} !== {1'b1, BASE, 4'd15, 1'b0})
        $display("FAIL stall_hold%0d: got v=%b a=%h l=%0d w=%b want v=1 a=%h l=15 w=0",
                 i, axi.awvalid, axi.awaddr, axi.awlen, axi.wvalid, BASE);
      else n_pass++;
    end
    awready_en = 1'b1;
    wait_w(w0 + 16, 100); idle(5);
    n_checks++; if (w_log.size() !== w0 + 16) $display("FAIL stall_w_count: got %0d want 16", w_log.size() - w0); else n_pass++;
    n_checks++; if (aw_addr_log.size() !== a0 + 1) $display("FAIL stall_aw_count: got %0d want 1", aw_addr_log.size() - a0); else n_pass++;
    n_checks++; if (early_w !== 0) $display("FAIL stall_early_w: got %0d cycles want 0", early_w); else n_pass++;
  endtask

  task automatic test_overflow();
    int a0, w0;
    frame_start_evt(); idle(5);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_before: got %b want 0", overflow); else n_pass++;
    wready_en = 1'b0;
    a0 = aw_addr_log.size(); w0 = w_log.size();
    send_pixels(100, 70);
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
    n_checks++; if (w_log.size() !== w0) $display("FAIL ovf_no_beats: got %0d want 0", w_log.size() - w0); else n_pass++;
    wready_en = 1'b1;
    wait_w(w0 + 64, 400); idle(20);
    n_checks++; if (w_log.size() !== w0 + 64) $display("FAIL ovf_w_count: got %0d want 64", w_log.size() - w0); else n_pass++;
    n_checks++; if (aw_addr_log.size() !== a0 + 4) $display("FAIL ovf_aw_count: got %0d want 4", aw_addr_log.size() - a0); else n_pass++;
    if (w_log.size() >= w0 + 64) begin
      for (int i = 0; i < 64; i++) begin
        n_checks++;
        if (w_log[w0+i][31:0] !== pix(100 + i))
          $display("FAIL ovf_beat%0d: got %h want %h", i, w_log[w0+i][31:0], pix(100 + i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_resp_err();
    int a0, w0, b0, c;
    frame_start_evt(); idle(5);
    n_checks++; if (resp_err !== 1'b0) $display("FAIL rerr_before: got %b want 0", resp_err); else n_pass++;
    b0 = b_cnt;
    bresp_val = 2'b10;
    send_pixels(180, 16);
    c = 0;
    while (b_cnt == b0 && c < 100) begin tick(); c++; end
    bresp_val = 2'b00;
    n_checks++; if (resp_err !== 1'b1) $display("FAIL rerr_set: got %b want 1", resp_err); else n_pass++;
    a0 = aw_addr_log.size(); w0 = w_log.size();
    send_pixels(196, 32);
    wait_w(w0 + 32, 300); idle(10);
    n_checks++; if (resp_err !== 1'b1) $display("FAIL rerr_sticky: got %b want 1", resp_err); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    n_checks++; if (b_cnt - b0 !== 3) $display("FAIL rerr_b_count: got %0d want 3", b_cnt - b0); else n_pass++;
    n_checks++; if (aw_addr_log.size() !== a0 + 2) $display("FAIL rerr_aw_count: got %0d want 2", aw_addr_log.size() - a0); else n_pass++;
    if (aw_addr_log.size() >= a0 + 2) begin
      n_checks++; if (aw_addr_log[a0] !== BASE + 32'h40) $display("FAIL rerr_aw0: got %h want %h", aw_addr_log[a0], BASE + 32'h40); else n_pass++;
      n_checks++; if (aw_addr_log[a0+1] !== BASE + 32'h80) $display("FAIL rerr_aw1: got %h want %h", aw_addr_log[a0+1], BASE + 32'h80); else n_pass++;
    end
    if (w_log.size() >= w0 + 32) begin
      n_checks++; if (w_log[w0+31] !== {1'b1, pix(227)}) $display("FAIL rerr_last_beat: got %h want %h", w_log[w0+31], {1'b1, pix(227)}); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int a0, w0, c;
    frame_start_evt(); idle(5);
    wready_en = 1'b0;
    send_pixels(230, 16);
    c = 0;
    while (!axi.wvalid && c < 30) begin tick(); c++; end
    n_checks++; if (axi.wvalid !== 1'b1) $display("FAIL rst_mid_in_data: got %b want 1", axi.wvalid); else n_pass++;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({axi.awvalid, axi.wvalid, axi.bready, axi.wlast} !== 4'b0000)
      $display("FAIL rst_mid_valids: got %b want 0000", {axi.awvalid, axi.wvalid, axi.bready, axi.wlast}); else n_pass++;
    n_checks++; if ({axi.awaddr, axi.awlen} !== 36'h0) $display("FAIL rst_mid_aw: got %h/%h want 0/0", axi.awaddr, axi.awlen); else n_pass++;
    n_checks++; if ({frame_done, overflow, resp_err} !== 3'b000)
      $display("FAIL rst_mid_flags: got %b want 000", {frame_done, overflow, resp_err}); else n_pass++;
    tick(); tick();
    rst_n = 1'b1; wready_en = 1'b1;
    a0 = aw_addr_log.size();
    send_pixels(0, 20);
    idle(40);
    n_checks++; if (aw_addr_log.size() !== a0) $display("FAIL rst_inactive_aw: got %0d bursts want 0", aw_addr_log.size() - a0); else n_pass++;
    n_checks++; if ({axi.awvalid, axi.wvalid} !== 2'b00) $display("FAIL rst_inactive_valid: got %b want 00", {axi.awvalid, axi.wvalid}); else n_pass++;
    // A fresh frame start brings capture back, from the base address.
    frame_start_evt(); idle(5);
    a0 = aw_addr_log.size(); w0 = w_log.size();
    send_pixels(10, 16);
    wait_w(w0 + 16, 200); idle(5);
    n_checks++; if (aw_addr_log.size() !== a0 + 1) $display("FAIL rst_resume_aw: got %0d want 1", aw_addr_log.size() - a0); else n_pass++;
    if (aw_addr_log.size() >= a0 + 1) begin
      n_checks++; if (aw_addr_log[a0] !== BASE) $display("FAIL rst_resume_addr: got %h want %h", aw_addr_log[a0], BASE); else n_pass++;
    end
    if (w_log.size() >= w0 + 1) begin
      n_checks++; if (w_log[w0][31:0] !== pix(10)) $display("FAIL rst_resume_data: got %h want %h", w_log[w0][31:0], pix(10)); else n_pass++;
    end
  endtask

  // ------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; cfg_base = BASE; cfg_en = 1'b1;
    vid_valid = 1'b0; vid_de = 1'b0; vid_vsync = 1'b0; vid_hsync = 1'b0;
    vid_r = 8'h0; vid_g = 8'h0; vid_b = 8'h0;
    awready_en = 1'b1; wready_en = 1'b1; bresp_val = 2'b00;

    test_reset();
    test_full_bursts();
    test_short_flush();
    test_aw_stall();
    test_overflow();
    test_resp_err();
    test_reset_mid_burst();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
